// File: rtl/peak_stream_reader.sv
// peak_stream_reader
//   Read side of the peak/index capture RAM pair. On a start pulse (the
//   capture block's peaks_ready) it sweeps all CHANNELS*NUM_PEAKS entries
//   through the RAM read port. Each entry leaves as one 64-bit AXI4-Stream
//   beat. Lives in the channel-0 process clock domain, the same domain as
//   the RAM write side.
//
//   Optional feature macro: PEAK_STREAM_TLAST_PER_CHANNEL_EN
//     defined   : tlast on the last peak of every channel (CHANNELS packets)
//     undefined : tlast on the final beat of the readout only
//
// Ports
//   clk            process clock
//   aresetn        asynchronous active-low reset
//   start          single-cycle readout request (peaks_ready)
//   ram_en         RAM read enable (registered)
//   ram_addr       RAM read address (registered, holds between reads)
//   peak_rddata    peak RAM read data, RD_LATENCY clocks after ram_en
//   idx_rddata     index RAM read data, same timing as peak_rddata
//   m_axis_*       stream master; tdata = {idx zero-ext 32, peak zero-ext 32},
//                  tuser = channel number of the beat
//   busy           readout in progress
//   done           one-cycle pulse coincident with the final beat handshake
//   overrun_cnt    saturating count of start pulses seen while busy
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; FIFO and read pipeline are empty
// READ   | issuing RAM reads whenever the output FIFO has credit
// DRAIN  | all reads issued; waiting for the final beat to be accepted
module peak_stream_reader #(
  parameter  int CHANNELS    = 8,
  parameter  int NUM_PEAKS   = 16,
  parameter  int VALUE_WIDTH = 16,
  parameter  int INDEX_WIDTH = 11,
  parameter  int ADDR_WIDTH  = 7,
  parameter  int RD_LATENCY  = 1,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  start,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [31:0]           peak_rddata,
  input  logic [31:0]           idx_rddata,
  output logic [63:0]           m_axis_tdata,
  output logic [CH_W-1:0]       m_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            overrun_cnt
);

  localparam int TOTAL = CHANNELS * NUM_PEAKS;
  localparam int KW    = $clog2(NUM_PEAKS);
  localparam int DEPTH = 4;

  localparam logic [ADDR_WIDTH:0]   LAST_ISSUE = (ADDR_WIDTH + 1)'(TOTAL - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_BEAT  = ADDR_WIDTH'(TOTAL - 1);
  localparam logic [ADDR_WIDTH-1:0] K_MASK     = ADDR_WIDTH'(NUM_PEAKS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            state;
  logic [ADDR_WIDTH:0]   rd_cnt;
  logic [RD_LATENCY-1:0] rd_pipe;
  logic [ADDR_WIDTH-1:0] ret_beat;

  logic [63:0]           fifo_data [DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_beat [DEPTH];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [2:0]            fifo_cnt;

  logic                  frame_start;
  logic                  push;
  logic                  pop;
  logic                  final_pop;
  logic                  credit_ok;
  int                    in_use;
  logic [ADDR_WIDTH-1:0] head_beat;
  logic [63:0]           push_data;
  logic                  unused_hi;

  // Upper RAM word bits carry nothing for this reader.
  assign unused_hi = ^{peak_rddata[31:VALUE_WIDTH], idx_rddata[31:INDEX_WIDTH]};

  assign push_data = {32'(idx_rddata[INDEX_WIDTH-1:0]),
                      32'(peak_rddata[VALUE_WIDTH-1:0])};

  assign frame_start = (state == S_IDLE) && start;
  assign push        = rd_pipe[RD_LATENCY-1];

  assign head_beat     = fifo_beat[rd_ptr];
  assign m_axis_tvalid = (fifo_cnt != 3'd0);
  assign m_axis_tdata  = fifo_data[rd_ptr];
  assign m_axis_tuser  = CH_W'(head_beat >> KW);
`ifdef PEAK_STREAM_TLAST_PER_CHANNEL_EN
  assign m_axis_tlast  = m_axis_tvalid && ((head_beat & K_MASK) == K_MASK);
`else
  assign m_axis_tlast  = m_axis_tvalid && (head_beat == LAST_BEAT);
`endif

  assign pop       = m_axis_tvalid && m_axis_tready;
  assign final_pop = pop && (head_beat == LAST_BEAT);
  assign done      = final_pop;
  assign busy      = (state != S_IDLE);

  // Slots committed after this edge: the read on the port now, reads in the
  // return pipe, buffered beats, minus the beat leaving this cycle. Counting
  // the departing beat as freed keeps 1 beat/clk at RD_LATENCY=2.
  always_comb begin
    in_use    = 0;
    in_use    = int'(ram_en) + $countones(rd_pipe) + int'(fifo_cnt) - int'(pop);
    credit_ok = (in_use < DEPTH);
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= S_IDLE;
      rd_cnt      <= '0;
      ram_en      <= 1'b0;
      ram_addr    <= '0;
      overrun_cnt <= 8'd0;
    end else begin
      ram_en <= 1'b0;
      case (state)
        S_IDLE: begin
          // FIFO is empty in IDLE, so the first read goes out immediately.
          if (start) begin
            ram_en   <= 1'b1;
            ram_addr <= '0;
            rd_cnt   <= (ADDR_WIDTH + 1)'(1);
            state    <= (TOTAL == 1) ? S_DRAIN : S_READ;
          end
        end
        S_READ: begin
          if (credit_ok) begin
            ram_en   <= 1'b1;
            ram_addr <= rd_cnt[ADDR_WIDTH-1:0];
            rd_cnt   <= rd_cnt + 1'b1;
            if (rd_cnt == LAST_ISSUE) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (final_pop) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // A start in the done cycle still sees DRAIN and counts as an overrun.
      if (start && (state != S_IDLE) && (overrun_cnt != 8'hFF))
        overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rd_pipe  <= '0;
      ret_beat <= '0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      fifo_cnt <= 3'd0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data[i] <= 64'd0;
        fifo_beat[i] <= '0;
      end
    end else begin
      rd_pipe[0] <= ram_en;
      for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];

      if (frame_start) begin
        ret_beat <= '0;
      end else if (push) begin
        ret_beat <= ret_beat + 1'b1;
      end

      if (push) begin
        fifo_data[wr_ptr] <= push_data;
        fifo_beat[wr_ptr] <= ret_beat;
        wr_ptr            <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      fifo_cnt <= fifo_cnt + 3'(push) - 3'(pop);
    end
  end

endmodule
